// File: rtl/quad_wave_lut.sv
// Quarter-wave DDFS waveform lookup: phase + offset -> sine/cosine/triangle/square.
// Ports: clk, rst_n (async low), in_valid, phase, phase_ofs, mode -> out_valid, out_data (3-cycle latency).
//
// Parameters:
//   DATA_WIDTH  signed sample width, AMP = 2^(DATA_WIDTH-1)-1
//   ADDR_WIDTH  quarter-wave table address width, N = 2^ADDR_WIDTH entries
//   PHASE_WIDTH phase word width, >= ADDR_WIDTH+2; DATA_WIDTH-1 >= ADDR_WIDTH
//
// The quarter-wave table holds round(AMP*sin((i+0.5)*pi/(2N))). It is built
// at elaboration with fixed-point integer arithmetic, so the contents are set
// by the parameters alone and no image file has to be supplied.
module quad_wave_lut #(
    parameter int DATA_WIDTH  = 12,
    parameter int ADDR_WIDTH  = 7,
    parameter int PHASE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [PHASE_WIDTH-1:0] phase,
    input  logic [PHASE_WIDTH-1:0] phase_ofs,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data
);

    localparam int MW = DATA_WIDTH - 1;
    localparam int N  = 1 << ADDR_WIDTH;
    localparam int SH = MW - ADDR_WIDTH;
    localparam int QW = ADDR_WIDTH + 2;

    localparam logic [MW-1:0] AMP = '1;
    localparam logic [PHASE_WIDTH-1:0] QTR =
        {2'b01, {(PHASE_WIDTH-2){1'b0}}};

    // pi in Q30
    localparam longint PI_Q30 = 64'sd3373259426;

    typedef enum logic [1:0] {
        M_SIN = 2'b00,
        M_COS = 2'b01,
        M_TRI = 2'b10,
        M_SQR = 2'b11
    } mode_e;

    // Taylor series of sin in Q30; every term stays below 2^63.
    function automatic logic [N*MW-1:0] build_rom();
        logic [N*MW-1:0] img;
        longint x, x2, term, acc, v;
        img = '0;
        for (int i = 0; i < N; i++) begin
            x    = (longint'(2*i+1) * PI_Q30) / longint'(4*N);
            x2   = (x * x) >>> 30;
            term = x;
            acc  = x;
            for (int k = 1; k <= 12; k++) begin
                term = -((term * x2) >>> 30)
                       / longint'((2*k) * (2*k+1));
                acc  = acc + term;
            end
            v = (longint'(AMP) * acc + (longint'(1) <<< 29)) >>> 30;
            img[i*MW +: MW] = v[MW-1:0];
        end
        return img;
    endfunction

    localparam logic [N*MW-1:0] ROM_IMG = build_rom();

    logic [MW-1:0] rom [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        assign rom[g] = ROM_IMG[g*MW +: MW];
    end

    // stage 1: offset add, cosine = sine advanced a quarter turn
    logic [PHASE_WIDTH-1:0] psum;
    logic                   unused_psum;

    always_comb begin
        psum = phase + phase_ofs + ((mode == 2'b01) ? QTR : '0);
    end

    // only the top QW bits address the table; the rest is truncated
    assign unused_psum = ^psum;

    logic          v1;
    logic [QW-1:0] p1;
    mode_e         m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            p1 <= '0;
            m1 <= M_SIN;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                p1 <= psum[PHASE_WIDTH-1 -: QW];
                m1 <= mode_e'(mode);
            end
        end
    end

    // stage 2: quadrant fold and table read
    logic [1:0]            q;
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] fa;

    always_comb begin
        q  = p1[QW-1 -: 2];
        a  = p1[ADDR_WIDTH-1:0];
        fa = q[0] ? ~a : a;
    end

    logic                  v2;
    logic                  neg2;
    mode_e                 m2;
    logic [ADDR_WIDTH-1:0] fa2;
    logic [MW-1:0]         mag2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            neg2 <= 1'b0;
            m2   <= M_SIN;
            fa2  <= '0;
            mag2 <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                neg2 <= q[1];
                m2   <= m1;
                fa2  <= fa;
                mag2 <= rom[fa];
            end
        end
    end

    // stage 3: waveform select and sign
    logic [MW-1:0]         mag_sel;
    logic [DATA_WIDTH-1:0] smag;
    logic [DATA_WIDTH-1:0] sample;

    always_comb begin
        mag_sel = '0;
        unique case (m2)
            M_SIN, M_COS: mag_sel = mag2;
            M_TRI:        mag_sel = MW'(fa2) << SH;
            M_SQR:        mag_sel = AMP;
            default:      mag_sel = '0;
        endcase
        // magnitude never reaches 2^MW, so negation cannot overflow
        smag   = {1'b0, mag_sel};
        sample = neg2 ? -smag : smag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                out_data <= sample;
            end
        end
    end

endmodule

// File: tb/tb_quad_wave_lut.sv
// Self-checking bench for quad_wave_lut: directed points, full phase sweep,
// random gaps and mid-stream reset against a real-valued waveform model.
module tb_quad_wave_lut;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] phase;
    logic [15:0] phase_ofs;
    logic [1:0]  mode;
    logic        out_valid;
    logic [11:0] out_data;

    int ncmp = 0;
    int nfail = 0;

    // expected-output history: index 0 = sampled at the latest edge
    logic        pv  [3];
    logic [11:0] pd  [3];
    logic [15:0] pph [3];
    logic [1:0]  pmd [3];
    logic [11:0] expd;

    logic [11:0] sobs  [65536];
    bit          shave [65536];

    quad_wave_lut #(
        .DATA_WIDTH (12),
        .ADDR_WIDTH (7),
        .PHASE_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .phase    (phase),
        .phase_ofs(phase_ofs),
        .mode     (mode),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    // waveform as a function of the 512-step truncated phase index k
    function automatic logic [11:0] ref_out(input logic [15:0] ph,
                                            input logic [15:0] of,
                                            input logic [1:0]  md);
        int  p, k, r;
        real x;
        p = (int'(ph) + int'(of) + ((md == 2'b01) ? 16384 : 0)) % 65536;
        k = p / 128;
        r = 0;
        case (md)
            2'b00, 2'b01: begin
                x = 2047.0 * $sin((real'(k) + 0.5) * 2.0 * PI / 512.0);
                r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
            end
            2'b10: begin
                if (k < 128)      r = k * 16;
                else if (k < 256) r = (255 - k) * 16;
                else if (k < 384) r = -(k - 256) * 16;
                else              r = -(511 - k) * 16;
            end
            default: r = (k < 256) ? 2047 : -2047;
        endcase
        return 12'(r);
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 3; i++) begin
            pv[i]  = 1'b0;
            pd[i]  = '0;
            pph[i] = '0;
            pmd[i] = '0;
        end
        expd = '0;
    endtask

    // drive one cycle, advance the model, check just after the edge
    task automatic cycle(input logic v, input logic [15:0] ph,
                         input logic [15:0] of, input logic [1:0] md,
                         input string tag);
        in_valid  = v;
        phase     = ph;
        phase_ofs = of;
        mode      = md;
        @(posedge clk);
        for (int i = 2; i > 0; i--) begin
            pv[i]  = pv[i-1];
            pd[i]  = pd[i-1];
            pph[i] = pph[i-1];
            pmd[i] = pmd[i-1];
        end
        pv[0]  = v;
        pd[0]  = ref_out(ph, of, md);
        pph[0] = ph + of;
        pmd[0] = md;
        if (pv[2]) expd = pd[2];
        #1;
        chkb({tag, "_valid"}, out_valid, pv[2]);
        chk({tag, "_data"}, out_data, expd);
        if (out_valid && pmd[2] == 2'b00) begin
            sobs[pph[2]]  = out_data;
            shave[pph[2]] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 2'b00, "idle");
    endtask

    // single sample, also compared against a hand-derived constant
    task automatic directed(input logic [15:0] ph, input logic [15:0] of,
                            input logic [1:0] md, input logic [11:0] lit,
                            input string tag);
        cycle(1'b1, ph, of, md, tag);
        cycle(1'b0, 16'h0, 16'h0, 2'b00, tag);
        cycle(1'b0, 16'h0, 16'h0, 2'b00, tag);
        chk({tag, "_const"}, out_data, lit);
        idle(1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        phase     = '0;
        phase_ofs = '0;
        mode      = '0;
        clear_model();

        repeat (2) @(posedge clk);
        #1;
        chkb("reset_valid", out_valid, 1'b0);
        chk("reset_data", out_data, 12'd0);
        rst_n = 1'b1;
        idle(2);

        directed(16'h0000, 16'h0000, 2'b00, 12'd13,    "sin_q0");
        directed(16'h4000, 16'h0000, 2'b00, 12'd2047,  "sin_q1");
        directed(16'h8000, 16'h0000, 2'b00, -12'sd13,  "sin_q2");
        directed(16'hC000, 16'h0000, 2'b00, -12'sd2047, "sin_q3");
        directed(16'h0000, 16'h0000, 2'b01, 12'd2047,  "cos_0");
        directed(16'hFFFF, 16'h0001, 2'b00, 12'd13,    "ofs_wrap");
        directed(16'h2000, 16'h0000, 2'b10, 12'd1024,  "tri_2000");
        directed(16'h6000, 16'h0000, 2'b10, 12'd1008,  "tri_6000");
        directed(16'h7FFF, 16'h0000, 2'b11, 12'd2047,  "sqr_7fff");
        directed(16'h8000, 16'h0000, 2'b11, -12'sd2047, "sqr_8000");

        for (int i = 0; i < 65536; i++) begin
            cycle(1'b1, 16'(i), 16'h0, 2'($urandom_range(0, 3)), "sweep");
        end
        idle(3);

        for (int p = 0; p < 32768; p++) begin
            if (shave[p] && shave[p + 32768]) begin
                chk("sine_symmetry", sobs[p], -sobs[p + 32768]);
            end
        end

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 2) != 0), 16'($urandom),
                  16'($urandom), 2'($urandom_range(0, 3)), "gaps");
        end
        idle(3);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)), "pre_rst");
        end
        #2;
        rst_n = 1'b0;
        #1;
        chkb("rst_mid_valid", out_valid, 1'b0);
        chk("rst_mid_data", out_data, 12'd0);
        clear_model();
        @(posedge clk);
        #2;
        chkb("rst_hold_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        idle(3);
        directed(16'h4000, 16'h0000, 2'b00, 12'd2047, "post_rst");

        for (int i = 0; i < 200; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  2'($urandom_range(0, 3)), "tail");
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nfail);
        $finish;
    end

endmodule
